// File: rtl/hid_rx_fifo.sv
// Multi-channel HID receive FIFO: edge-triggered capture per channel, with DATA/STATUS/CTRL
// registers on the 64-bit HID bus, sticky overflow, flush, and a registered level interrupt.
module hid_rx_fifo #(
    parameter int NCH    = 2,
    parameter int DEPTH  = 16,
    parameter int DATA_W = 9,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NCH-1:0]          rx_valid_i,
    input  logic [NCH*DATA_W-1:0]   rx_data_i,
    input  logic                    hid_en,
    input  logic [7:0]              hid_we,
    input  logic [18:0]             hid_addr,
    input  logic [63:0]             hid_wrdata,
    output logic [63:0]             hid_rddata,
    output logic                    irq_o
);
    localparam int PTR_W = CNT_W - 1;

    logic [DATA_W-1:0] mem [NCH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NCH];
    logic [PTR_W-1:0]  rd_ptr [NCH];
    logic [CNT_W-1:0]  count  [NCH];
    logic [NCH-1:0]    overflow, irq_en, rx_prev;

    logic [NCH-1:0] sel, empty, full, push, do_push, do_pop, ovf_set, flush, clr_ovf, ctrl_wr;
    logic           wr_acc, rd_acc;
    logic [2:0]     reg_addr;
    logic [63:0]    rd_value;
    logic           unused_bits;

    assign wr_acc      = hid_en & (|hid_we);
    assign rd_acc      = hid_en & ~(|hid_we);
    assign reg_addr    = hid_addr[5:3];
    assign unused_bits = ^{hid_addr[18:9], hid_addr[2:0], hid_wrdata[63:3]};

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            sel[c]     = (hid_addr[8:6] == 3'(c));
            empty[c]   = (count[c] == '0);
            full[c]    = (count[c] == CNT_W'(DEPTH));
            push[c]    = rx_valid_i[c] & ~rx_prev[c];
            ctrl_wr[c] = wr_acc & sel[c] & (reg_addr == 3'd2);
            flush[c]   = ctrl_wr[c] & hid_wrdata[0];
            clr_ovf[c] = ctrl_wr[c] & hid_wrdata[1];
            do_pop[c]  = wr_acc & sel[c] & (reg_addr == 3'd0) & ~empty[c] & ~flush[c];
            do_push[c] = push[c] & ~flush[c] & (~full[c] | do_pop[c]);
            ovf_set[c] = push[c] & ~flush[c] & full[c] & ~do_pop[c];
        end
    end

    always_comb begin
        rd_value = '0;
        for (int c = 0; c < NCH; c++) begin
            if (sel[c]) begin
                case (reg_addr)
                    3'd0: begin
                        rd_value[DATA_W-1:0] = empty[c] ? '0 : mem[c][rd_ptr[c]];
                        rd_value[DATA_W]     = empty[c];
                    end
                    3'd1: begin
                        rd_value[CNT_W-1:0] = count[c];
                        rd_value[16]        = empty[c];
                        rd_value[17]        = full[c];
                        rd_value[18]        = overflow[c];
                    end
                    3'd2: rd_value[2] = irq_en[c];
                    default: ;
                endcase
            end
        end
    end

    // Storage needs no reset; emptiness is tracked by the counters alone.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NCH; c++) begin
            if (do_push[c])
                mem[c][wr_ptr[c]] <= rx_data_i[c*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_prev    <= '1;
            overflow   <= '0;
            irq_en     <= '0;
            irq_o      <= 1'b0;
            hid_rddata <= '0;
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            rx_prev <= rx_valid_i;
            irq_o   <= |(irq_en & ~empty);
            if (rd_acc)
                hid_rddata <= rd_value;
            for (int c = 0; c < NCH; c++) begin
                if (flush[c]) begin
                    wr_ptr[c] <= '0;
                    rd_ptr[c] <= '0;
                    count[c]  <= '0;
                end else begin
                    if (do_push[c])
                        wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                    if (do_pop[c])
                        rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                    if (do_push[c] && !do_pop[c])
                        count[c] <= count[c] + CNT_W'(1);
                    else if (do_pop[c] && !do_push[c])
                        count[c] <= count[c] - CNT_W'(1);
                end
                // A new overflow outranks a clear arriving in the same cycle.
                if (ovf_set[c])
                    overflow[c] <= 1'b1;
                else if (clr_ovf[c])
                    overflow[c] <= 1'b0;
                if (ctrl_wr[c])
                    irq_en[c] <= hid_wrdata[2];
            end
        end
    end
endmodule

// File: tb/tb_hid_rx_fifo.sv
// Directed self-checking bench for hid_rx_fifo with NCH=2, DEPTH=16, DATA_W=9.
module tb_hid_rx_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rx_valid;
    logic [17:0] rx_data;
    logic        hid_en;
    logic [7:0]  hid_we;
    logic [18:0] hid_addr;
    logic [63:0] hid_wrdata;
    logic [63:0] hid_rddata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] ST_EMPTY = 64'h1_0000;
    localparam logic [63:0] ST_FULL  = 64'h2_0000;
    localparam logic [63:0] ST_OVF   = 64'h4_0000;

    hid_rx_fifo #(.NCH(2), .DEPTH(16), .DATA_W(9)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .hid_en     (hid_en),
        .hid_we     (hid_we),
        .hid_addr   (hid_addr),
        .hid_wrdata (hid_wrdata),
        .hid_rddata (hid_rddata),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] mk_addr(input int c, input int r);
        return {10'd0, 3'(c), 3'(r), 3'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int c, input logic [8:0] d);
        rx_data[c*9 +: 9] = d;
        rx_valid[c] = 1'b1;
        tick();
        rx_valid[c] = 1'b0;
        tick();
    endtask

    task automatic bus_write(input int c, input int r, input logic [63:0] d);
        hid_en     = 1'b1;
        hid_we     = 8'hFF;
        hid_addr   = mk_addr(c, r);
        hid_wrdata = d;
        tick();
        hid_en = 1'b0;
        hid_we = 8'h00;
    endtask

    task automatic bus_read(input int c, input int r, output logic [63:0] v);
        hid_en   = 1'b1;
        hid_we   = 8'h00;
        hid_addr = mk_addr(c, r);
        tick();
        hid_en = 1'b0;
        v = hid_rddata;
    endtask

    task automatic test_reset();
        logic [63:0] v;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_tests++; if (hid_rddata !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_rddata: got %h expected %h", hid_rddata, 64'd0); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
        bus_read(0, 1, v);
        n_tests++; if (v !== ST_EMPTY) begin n_fail++; $display("[TB] FAIL reset_status0: got %h expected %h", v, ST_EMPTY); end
        bus_read(1, 1, v);
        n_tests++; if (v !== ST_EMPTY) begin n_fail++; $display("[TB] FAIL reset_status1: got %h expected %h", v, ST_EMPTY); end
        bus_read(0, 2, v);
        n_tests++; if (v !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_ctrl0: got %h expected %h", v, 64'd0); end
    endtask

    task automatic test_basic();
        logic [63:0] v;
        pulse(0, 9'h0F0);
        pulse(0, 9'h11C);
        pulse(0, 9'h05A);
        bus_read(0, 1, v);
        n_tests++; if (v !== 64'h3) begin n_fail++; $display("[TB] FAIL basic_status: got %h expected %h", v, 64'h3); end
        bus_read(0, 0, v);
        n_tests++; if (v !== 64'h0F0) begin n_fail++; $display("[TB] FAIL basic_data0: got %h expected %h", v, 64'h0F0); end
        bus_write(0, 0, 64'hDEAD);
        bus_read(0, 0, v);
        n_tests++; if (v !== 64'h11C) begin n_fail++; $display("[TB] FAIL basic_data1: got %h expected %h", v, 64'h11C); end
        bus_read(1, 1, v);
        n_tests++; if (v !== ST_EMPTY) begin n_fail++; $display("[TB] FAIL basic_ch1_status: got %h expected %h", v, ST_EMPTY); end
        bus_read(3, 1, v);
        n_tests++; if (v !== 64'd0) begin n_fail++; $display("[TB] FAIL basic_bad_channel: got %h expected %h", v, 64'd0); end
        bus_read(0, 5, v);
        n_tests++; if (v !== 64'd0) begin n_fail++; $display("[TB] FAIL basic_reg5: got %h expected %h", v, 64'd0); end
        bus_write(0, 0, 64'd0);
        bus_write(0, 0, 64'd0);
        bus_read(0, 0, v);
        n_tests++; if (v !== 64'h200) begin n_fail++; $display("[TB] FAIL basic_data_empty: got %h expected %h", v, 64'h200); end
    endtask

    task automatic test_overflow();
        logic [63:0] v;
        for (int i = 0; i < 17; i++) pulse(0, 9'(i));
        bus_read(0, 1, v);
        n_tests++; if (v !== (64'd16 | ST_FULL | ST_OVF)) begin n_fail++; $display("[TB] FAIL ovf_status_full: got %h expected %h", v, 64'd16 | ST_FULL | ST_OVF); end
        for (int i = 0; i < 16; i++) begin
            bus_read(0, 0, v);
            n_tests++; if (v !== 64'(i)) begin n_fail++; $display("[TB] FAIL ovf_drain[%0d]: got %h expected %h", i, v, 64'(i)); end
            bus_write(0, 0, 64'd0);
        end
        bus_read(0, 1, v);
        n_tests++; if (v !== (ST_EMPTY | ST_OVF)) begin n_fail++; $display("[TB] FAIL ovf_status_drained: got %h expected %h", v, ST_EMPTY | ST_OVF); end
        bus_write(0, 2, 64'h2);
        bus_read(0, 1, v);
        n_tests++; if (v !== ST_EMPTY) begin n_fail++; $display("[TB] FAIL ovf_cleared: got %h expected %h", v, ST_EMPTY); end
    endtask

    task automatic test_push_pop_full();
        logic [63:0] v;
        logic [63:0] exp;
        for (int i = 0; i < 16; i++) pulse(0, 9'(i));
        bus_read(0, 1, v);
        n_tests++; if (v !== (64'd16 | ST_FULL)) begin n_fail++; $display("[TB] FAIL full_status: got %h expected %h", v, 64'd16 | ST_FULL); end
        rx_data[8:0] = 9'h1AA;
        rx_valid[0] = 1'b1;
        bus_write(0, 0, 64'd0);
        rx_valid[0] = 1'b0;
        tick();
        bus_read(0, 1, v);
        n_tests++; if (v !== (64'd16 | ST_FULL)) begin n_fail++; $display("[TB] FAIL full_simul_status: got %h expected %h", v, 64'd16 | ST_FULL); end
        for (int i = 0; i < 16; i++) begin
            exp = (i < 15) ? 64'(i + 1) : 64'h1AA;
            bus_read(0, 0, v);
            n_tests++; if (v !== exp) begin n_fail++; $display("[TB] FAIL full_drain[%0d]: got %h expected %h", i, v, exp); end
            bus_write(0, 0, 64'd0);
        end
        bus_read(0, 1, v);
        n_tests++; if (v !== ST_EMPTY) begin n_fail++; $display("[TB] FAIL full_drained: got %h expected %h", v, ST_EMPTY); end
    endtask

    task automatic test_empty_corner();
        logic [63:0] v;
        bus_write(0, 0, 64'd0);
        bus_read(0, 1, v);
        n_tests++; if (v !== ST_EMPTY) begin n_fail++; $display("[TB] FAIL empty_pop: got %h expected %h", v, ST_EMPTY); end
        rx_data[8:0] = 9'h077;
        rx_valid[0] = 1'b1;
        bus_write(0, 0, 64'd0);
        rx_valid[0] = 1'b0;
        tick();
        bus_read(0, 1, v);
        n_tests++; if (v !== 64'd1) begin n_fail++; $display("[TB] FAIL empty_simul_status: got %h expected %h", v, 64'd1); end
        bus_read(0, 0, v);
        n_tests++; if (v !== 64'h077) begin n_fail++; $display("[TB] FAIL empty_simul_data: got %h expected %h", v, 64'h077); end
        bus_write(0, 0, 64'd0);
    endtask

    task automatic test_flush_irq();
        logic [63:0] v;
        bus_write(1, 2, 64'h4);
        bus_read(1, 2, v);
        n_tests++; if (v !== 64'h4) begin n_fail++; $display("[TB] FAIL irq_ctrl_read: got %h expected %h", v, 64'h4); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_idle: got %b expected 0", irq); end
        pulse(1, 9'h033);
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_assert: got %b expected 1", irq); end
        rx_data[17:9] = 9'h044;
        rx_valid[1] = 1'b1;
        bus_write(1, 2, 64'h5);
        rx_valid[1] = 1'b0;
        tick();
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_after_flush: got %b expected 0", irq); end
        bus_read(1, 1, v);
        n_tests++; if (v !== ST_EMPTY) begin n_fail++; $display("[TB] FAIL flush_status: got %h expected %h", v, ST_EMPTY); end
        bus_write(1, 2, 64'h0);
    endtask

    task automatic test_reset_mid();
        logic [63:0] v;
        for (int i = 0; i < 5; i++) pulse(0, 9'(8'h30 + i));
        bus_read(0, 1, v);
        n_tests++; if (v !== 64'd5) begin n_fail++; $display("[TB] FAIL rst_pre_status: got %h expected %h", v, 64'd5); end
        rx_data[8:0] = 9'h0CC;
        rx_valid[0] = 1'b1;
        tick();
        rst = 1'b1;
        hid_en = 1'b1;
        hid_we = 8'h00;
        hid_addr = mk_addr(0, 1);
        repeat (2) tick();
        rst = 1'b0;
        hid_en = 1'b0;
        n_tests++; if (hid_rddata !== 64'd0) begin n_fail++; $display("[TB] FAIL rst_rddata: got %h expected %h", hid_rddata, 64'd0); end
        repeat (3) tick();
        bus_read(0, 1, v);
        n_tests++; if (v !== ST_EMPTY) begin n_fail++; $display("[TB] FAIL rst_held_level: got %h expected %h", v, ST_EMPTY); end
        rx_valid[0] = 1'b0;
        tick();
        pulse(0, 9'h0AB);
        bus_read(0, 1, v);
        n_tests++; if (v !== 64'd1) begin n_fail++; $display("[TB] FAIL rst_new_edge_status: got %h expected %h", v, 64'd1); end
        bus_read(0, 0, v);
        n_tests++; if (v !== 64'h0AB) begin n_fail++; $display("[TB] FAIL rst_new_edge_data: got %h expected %h", v, 64'h0AB); end
    endtask

    initial begin
        rst        = 1'b1;
        rx_valid   = 2'b00;
        rx_data    = '0;
        hid_en     = 1'b0;
        hid_we     = 8'h00;
        hid_addr   = '0;
        hid_wrdata = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_push_pop_full();
        test_empty_corner();
        test_flush_irq();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hid_rx_fifo.md
Name: hid_rx_fifo

Overview:
Parametrised multi-channel receive FIFO for HID input devices (PS/2 keyboard, mouse, further serial sources). It replaces the fixed single-channel vendor FIFO primitive with portable inferred storage. Each channel captures a data word on the rising edge of its source's ready strobe and exposes data, status and control registers on the 64-bit HID bus. Sits between the ps2/serial receivers and the HID read-data mux; adds overflow detection, flush and a level interrupt.

Parameters:
NCH, 2, number of independent channels (1..8)
DEPTH, 16, entries per channel; power of two, >=2
DATA_W, 9, bits per entry (scan code + released flag for PS/2); 1..16
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override)

Ports:
clk_i  in  1  system clock; all logic on posedge
rst_i  in  1  synchronous reset, active-high
rx_valid_i  in  NCH  per-channel ready level from receiver; a rising edge means new data
rx_data_i  in  NCH*DATA_W  per-channel data; channel c at [c*DATA_W +: DATA_W], sampled on the push cycle
hid_en  in  1  bus access strobe, already qualified by the parent address decode
hid_we  in  8  byte write enables; a write is any access with |hid_we=1
hid_addr  in  19  byte address; [8:6]=channel, [5:3]=register, other bits ignored
hid_wrdata  in  64  write data
hid_rddata  out  64  registered read data
irq_o  out  1  level interrupt

Behaviour:
- Reset: all FIFOs empty, all counts 0, overflow flags 0, irq_en 0, hid_rddata=0, irq_o=0.
- Edge-detect registers reset to 1, so a level held high across reset produces no push.
- Push for channel c: rx_valid_i[c]=1 and its previous-cycle value was 0. One push per edge.
  - Not full: write rx_data_i slice at the write pointer, increment count.
  - Full with no simultaneous pop: data dropped, overflow[c] set (sticky).
- Channel access: addresses with channel >= NCH read 0; writes to them are ignored.
- Register 0, DATA:
  - Read returns {zeros, empty, head[DATA_W-1:0]}, with empty at bit DATA_W. Reading does not pop.
  - Head reads as 0 when empty.
  - Any write pops one entry; the write data is ignored.
  - Pop when empty: no effect on pointers or count.
- Register 1, STATUS (read-only): [CNT_W-1:0]=count, [16]=empty, [17]=full, [18]=overflow, rest 0.
- Register 2, CTRL:
  - Write: bit0=flush (self-clearing), bit1=clear overflow (self-clearing), bit2=irq_en (stored).
  - Read: bit2=irq_en, rest 0.
- Registers 3..7: read 0, writes ignored.
- Read latency: one cycle. An access with hid_en=1 and hid_we=0 loads hid_rddata on the next posedge. hid_rddata holds its value at all other times.
  - Status and data reads reflect state before any same-cycle push or pop.
- Simultaneous events, per channel:
  - Push and pop on a non-empty FIFO: both happen, count unchanged. This holds when full: no overflow, and the new word is stored.
  - Push and pop on an empty FIFO: the pop is ignored, the push is stored, count=1.
  - Flush and push in the same cycle: flush wins, push discarded, overflow not set.
  - Flush and clear-overflow in one write: both take effect.
  - Overflow set and clear-overflow in the same cycle: the set wins.
- Pointers are CNT_W-1 bits and wrap modulo DEPTH naturally. Count saturates at DEPTH by construction; it never wraps.
- irq_o is registered: irq_o = OR over c of (irq_en[c] & ~empty[c]), updated every cycle (one-cycle lag after a state change).
- Reset mid-operation: all state clears in the cycle rst_i is sampled high, regardless of pending pushes or bus access. hid_rddata goes to 0.

Test Plan:
- Basic: NCH=2, DEPTH=16. Pulse rx_valid_i[0] three times with data 0x0F0, 0x11C, 0x05A. STATUS ch0 -> count=3, empty=0. Read DATA -> 0x0F0 one cycle later. Pop, read -> 0x11C. Ch1 STATUS stays empty=1.
- Full/overflow: 17 edges on ch0 with data 0..16 -> count=16, full=1, overflow=1. 16 pop/read pairs return 0..15, then empty=1 (data 16 lost). CTRL write 0x2 -> overflow=0.
- Simultaneous at full: fill to 16 (data 0..15). Push 0x1AA in the same cycle as a pop -> count=16, overflow=0. The 16th pop returns 0x1AA.
- Empty corner: pop on empty -> count stays 0. Push and pop in the same cycle on empty -> count=1, DATA=pushed value.
- Flush/irq: CTRL write 0x4 on ch1, push 1 word -> irq_o=1 within 2 cycles. CTRL write 0x5 with a same-cycle push -> count=0, irq_o=0, overflow=0.
- Reset: hold rx_valid_i[0]=1 through rst_i and release with 5 entries queued -> count=0, hid_rddata=0, no push after reset until rx_valid_i falls and rises again.
